layer_scheduler: RTL and testbench

//  Batch sequencer for the ConvNN accelerator. It walks IMAGE_NUM input images

---
 rtl/layer_scheduler.sv | 127 ++++++++++++
 tb/tb_layer_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scheduler.sv
// Batch sequencer: loads each image in turn, then starts every compute layer
// in order and waits for its done pulse before moving on.
module layer_scheduler #(
  parameter int IMAGE_NUM = 10,
  parameter int LAYER_NUM = 3,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 abort,
  input  logic                 load_ack,
  input  logic [LAYER_NUM-1:0] layer_calc_fin,
  output logic                 load_req,
  output logic [LAYER_NUM-1:0] layer_start,
  output logic [IDX_W-1:0]     image_idx,
  output logic [2:0]           layer_idx,
  output logic                 busy,
  output logic                 batch_done,
  output logic                 err_fin
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0]       LAST_LAYER = 3'(LAYER_NUM - 1);
  localparam logic [IDX_W-1:0] LAST_IMAGE = IDX_W'(IMAGE_NUM - 1);

  logic [2:0]           state_reg;
  logic [2:0]           state_next;
  logic [IDX_W-1:0]     image_next;
  logic [2:0]           layer_next;
  logic                 err_next;
  logic [LAYER_NUM-1:0] cur_mask;
  logic [LAYER_NUM-1:0] start_next;
  logic                 fin_hit;
  logic                 fin_bad;

  // cur_mask selects the layer being waited on; start_next is the registered pulse.
  genvar gi;
  generate
    for (gi = 0; gi < LAYER_NUM; gi++) begin : g_mask
      assign cur_mask[gi]   = (layer_idx == 3'(gi));
      assign start_next[gi] = (state_next == S_START) && (layer_next == 3'(gi));
    end
  endgenerate

  assign fin_hit = (state_reg == S_WAIT) && |(layer_calc_fin & cur_mask);
  assign fin_bad = (state_reg == S_WAIT) ? |(layer_calc_fin & ~cur_mask)
                                         : |layer_calc_fin;

  always_comb begin
    state_next = state_reg;
    image_next = image_idx;
    layer_next = layer_idx;
    err_next   = err_fin;
    if (abort) begin
      state_next = S_IDLE;
      image_next = '0;
      layer_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (enable) begin
            state_next = S_LOAD;
            image_next = '0;
            layer_next = '0;
            err_next   = 1'b0;
          end
        end
        S_LOAD:  if (load_ack) state_next = S_START;
        S_START: state_next = S_WAIT;
        S_WAIT: begin
          if (fin_hit) begin
            if (layer_idx == LAST_LAYER) begin
              state_next = S_NEXT;
            end else begin
              layer_next = layer_idx + 3'd1;
              state_next = S_START;
            end
          end
        end
        S_NEXT: begin
          layer_next = '0;
          if (image_idx == LAST_IMAGE) begin
            state_next = S_DONE;
          end else begin
            image_next = image_idx + IDX_W'(1);
            state_next = S_LOAD;
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
    // A stray done pulse is flagged even when the expected bit also advances the FSM.
    if (fin_bad) err_next = 1'b1;
  end

  // Outputs are decoded from the next state so each one comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      image_idx   <= '0;
      layer_idx   <= '0;
      err_fin     <= 1'b0;
      load_req    <= 1'b0;
      layer_start <= '0;
      busy        <= 1'b0;
      batch_done  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      image_idx   <= image_next;
      layer_idx   <= layer_next;
      err_fin     <= err_next;
      load_req    <= (state_next == S_LOAD);
      layer_start <= start_next;
      busy        <= (state_next != S_IDLE);
      batch_done  <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Randomized and directed bench for layer_scheduler, checked every cycle
// against a phase-level model of the batch walk.
module tb_layer_scheduler;
  localparam int IMG = 10;
  localparam int LAY = 3;
  localparam int IW  = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_FIRE = 2, P_WAIT = 3, P_NEXT = 4, P_DONE = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           enable = 1'b0;
  logic           abort = 1'b0;
  logic           load_ack = 1'b0;
  logic [LAY-1:0] layer_calc_fin = '0;
  logic           load_req;
  logic [LAY-1:0] layer_start;
  logic [IW-1:0]  image_idx;
  logic [2:0]     layer_idx;
  logic           busy;
  logic           batch_done;
  logic           err_fin;

  always #5 clk = ~clk;

  layer_scheduler #(.IMAGE_NUM(IMG), .LAYER_NUM(LAY), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort), .load_ack(load_ack),
    .layer_calc_fin(layer_calc_fin), .load_req(load_req), .layer_start(layer_start),
    .image_idx(image_idx), .layer_idx(layer_idx), .busy(busy),
    .batch_done(batch_done), .err_fin(err_fin)
  );

  int m_phase, m_img, m_lay;
  bit m_err;
  int errors = 0, checks = 0;
  int ack_delay = 0, fin_delay = 0, cnt_load = 0, cnt_wait = 0;
  bit hold_enable = 1'b0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_IDLE; m_img = 0; m_lay = 0; m_err = 1'b0;
  endfunction

  function automatic void model_step();
    bit unexpected = 1'b0;
    for (int i = 0; i < LAY; i++)
      if (layer_calc_fin[i] && !(m_phase == P_WAIT && i == m_lay)) unexpected = 1'b1;
    if (abort) begin
      m_phase = P_IDLE; m_img = 0; m_lay = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (enable) begin m_phase = P_LOAD; m_img = 0; m_lay = 0; m_err = 1'b0; end
        P_LOAD: if (load_ack) m_phase = P_FIRE;
        P_FIRE: m_phase = P_WAIT;
        P_WAIT: if (layer_calc_fin[m_lay]) begin
          if (m_lay < LAY - 1) begin m_lay++; m_phase = P_FIRE; end
          else m_phase = P_NEXT;
        end
        P_NEXT: begin
          m_lay = 0;
          if (m_img == IMG - 1) m_phase = P_DONE;
          else begin m_img++; m_phase = P_LOAD; end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    if (unexpected) m_err = 1'b1;
  endfunction

  task automatic check_all();
    logic [31:0] exp_start;
    exp_start = (m_phase == P_FIRE) ? (32'd1 << m_lay) : 32'd0;
    chk("load_req",    32'(load_req),    32'(m_phase == P_LOAD));
    chk("layer_start", 32'(layer_start), exp_start);
    chk("image_idx",   32'(image_idx),   32'(m_img));
    chk("layer_idx",   32'(layer_idx),   32'(m_lay));
    chk("busy",        32'(busy),        32'(m_phase != P_IDLE));
    chk("batch_done",  32'(batch_done),  32'(m_phase == P_DONE));
    chk("err_fin",     32'(err_fin),     32'(m_err));
    if (batch_done === 1'b1) begin
      done_seen++;
      $display("batch complete at %0t (image_idx=%0d)", $time, image_idx);
    end
  endtask

  // Default responder: ack / fin arrive a programmable number of cycles after the request.
  task automatic drive_responses();
    abort  = 1'b0;
    enable = hold_enable;
    cnt_load = (m_phase == P_LOAD) ? cnt_load + 1 : 0;
    cnt_wait = (m_phase == P_WAIT) ? cnt_wait + 1 : 0;
    load_ack = (m_phase == P_LOAD) && (cnt_load > ack_delay);
    layer_calc_fin = '0;
    if (m_phase == P_WAIT && cnt_wait > fin_delay) layer_calc_fin[m_lay] = 1'b1;
  endtask

  task automatic cycle();
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    drive_responses();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] starts[$];
    int         imgs[$];
    int         lit_start[6] = '{1, 2, 4, 1, 2, 4};
    int         lit_img[6]   = '{0, 0, 0, 1, 1, 1};
    int         req_cycles, start_before, wrap, prev_img;

    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all();
    drive_responses();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("reset_busy", 32'(busy), 32'd0);

    // Test 1: full batch, ack and fin two cycles after each request
    ack_delay = 2; fin_delay = 2; done_seen = 0;
    enable = 1'b1;
    cycle();
    chk("t1_load_latency", 32'(load_req), 32'd1);
    hold_enable = 1'b0;
    for (int n = 0; n < 600 && m_phase != P_DONE; n++) begin
      cycle();
      if (layer_start !== '0) begin
        starts.push_back(layer_start);
        imgs.push_back(int'(image_idx));
      end
    end
    chk("t1_reached_done", 32'(m_phase == P_DONE), 32'd1);
    cycle();
    chk("t1_start_count", 32'(starts.size()), 32'd30);
    for (int i = 0; i < 6 && i < starts.size(); i++) begin
      chk("t1_start_seq", 32'(starts[i]), 32'(lit_start[i]));
      chk("t1_start_img", 32'(imgs[i]), 32'(lit_img[i]));
    end
    chk("t1_batch_done_count", 32'(done_seen), 32'd1);
    $display("test1: %0d layer starts, %0d batch_done", starts.size(), done_seen);

    // Test 2: slow load_ack
    ack_delay = 5; fin_delay = 0; req_cycles = 0; start_before = 0;
    enable = 1'b1;
    for (int n = 0; n < 40 && m_phase != P_FIRE; n++) begin
      cycle();
      if (load_req === 1'b1) req_cycles++;
      if (m_phase != P_FIRE && layer_start !== '0) start_before++;
    end
    chk("t2_req_cycles", 32'(req_cycles), 32'd6);
    chk("t2_start_before_ack", 32'(start_before), 32'd0);
    abort = 1'b1;
    cycle();
    $display("test2: load_req held %0d cycles", req_cycles);

    // Test 3: wrong fin while waiting on layer 0
    ack_delay = 0; fin_delay = 1000;
    enable = 1'b1;
    for (int n = 0; n < 20 && m_phase != P_WAIT; n++) cycle();
    layer_calc_fin = 3'b100;
    cycle();
    chk("t3_err_set", 32'(err_fin), 32'd1);
    chk("t3_layer_held", 32'(layer_idx), 32'd0);
    fin_delay = 0;
    for (int n = 0; n < 20 && m_lay != 1; n++) cycle();
    chk("t3_advance", 32'(layer_idx), 32'd1);
    abort = 1'b1;
    cycle();
    chk("t3_err_kept", 32'(err_fin), 32'd1);
    $display("test3: err_fin=%0d after abort", err_fin);

    // Test 4: abort while waiting on image 1, layer 2
    ack_delay = 1; fin_delay = 3;
    enable = 1'b1;
    cycle();
    chk("t4_err_cleared", 32'(err_fin), 32'd0);
    for (int n = 0; n < 300 && !(m_phase == P_WAIT && m_img == 1 && m_lay == 2); n++) cycle();
    abort = 1'b1;
    layer_calc_fin = '0;
    cycle();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_image", 32'(image_idx), 32'd0);
    chk("t4_layer", 32'(layer_idx), 32'd0);
    chk("t4_no_done", 32'(batch_done), 32'd0);
    enable = 1'b1;
    cycle();
    chk("t4_restart_req", 32'(load_req), 32'd1);
    chk("t4_restart_img", 32'(image_idx), 32'd0);
    abort = 1'b1;
    cycle();
    $display("test4: abort and restart done");

    // Test 5: asynchronous reset while loading
    ack_delay = 10;
    enable = 1'b1;
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_load_req", 32'(load_req), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_outputs_zero", 32'({layer_start, image_idx, layer_idx, batch_done, err_fin}), 32'd0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    enable = 1'b0;
    repeat (4) cycle();
    chk("t5_idle", 32'(busy), 32'd0);
    $display("test5: async reset mid-load done");

    // Test 6: enable held high, back-to-back batches
    ack_delay = 0; fin_delay = 0; done_seen = 0; wrap = 0;
    prev_img = int'(image_idx);
    hold_enable = 1'b1; enable = 1'b1;
    for (int n = 0; n < 500 && done_seen < 2; n++) begin
      cycle();
      if (prev_img == IMG - 1 && image_idx === IW'(0)) wrap++;
      prev_img = int'(image_idx);
    end
    chk("t6_done_count", 32'(done_seen), 32'd2);
    chk("t6_wrap", 32'(wrap), 32'd1);
    hold_enable = 1'b0;
    abort = 1'b1;
    cycle();
    $display("test6: %0d batches, %0d index wraps", done_seen, wrap);

    // Random traffic with stray pulses, stray acks and occasional aborts
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        ack_delay = $urandom_range(0, 4);
        fin_delay = $urandom_range(0, 4);
      end
      hold_enable = ($urandom_range(0, 3) != 0);
      enable = hold_enable;
      if ($urandom_range(0, 29) == 0) layer_calc_fin = layer_calc_fin | LAY'($urandom);
      if ($urandom_range(0, 9) == 0) load_ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) abort = 1'b1;
      cycle();
    end
    $display("random phase: %0d batches completed", done_seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
